// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: program-counter handshake, instruction-memory
// request/ack port, flush, and the decode-side instruction queue head.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              pc_ready;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              flush;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              addr_fault;

    // Fetch unit side
    modport slave (
        input  pc, pc_valid, imem_ack, imem_rdata, flush, instr_ready,
        output pc_ready, imem_req, imem_addr, instr, instr_pc, instr_valid, addr_fault
    );

    // Surrounding system side (PC, memory, decode)
    modport master (
        output pc, pc_valid, imem_ack, imem_rdata, flush, instr_ready,
        input  pc_ready, imem_req, imem_addr, instr, instr_pc, instr_valid, addr_fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: takes fetch addresses from the PC, issues one
// word read at a time to instruction memory and queues the returned words
// (with their addresses) for decode. Out-of-range or misaligned addresses
// are turned into a NOP with a one-cycle addr_fault pulse. Flush drops the
// queue and any in-flight response.
module instr_fetch_unit #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LIMIT  = 1020,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_unit_if.slave    bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_LIMIT);
    localparam logic [DATA_W-1:0] NOP   = DATA_W'(32'h0000_0013);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t            state_reg;
    logic              req_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              fault_reg;

    logic [DATA_W-1:0] instr_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem    [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              pc_ready_next;
    logic              accept;
    logic              pc_legal;
    logic              ack_push;
    logic              fault_push;
    logic              push;
    logic              pop;
    logic              queue_valid;
    logic [DATA_W-1:0] push_instr;
    logic [ADDR_W-1:0] push_pc;
    logic [FIFO_DEPTH-1:0] wr_en;

    // pc_ready is held low while reset is asserted, even though IDLE/empty
    // would otherwise allow acceptance.
    assign pc_ready_next = rst && (state_reg == IDLE) && !bus.flush && (count_reg < FULL);
    assign accept        = bus.pc_valid && pc_ready_next;
    assign pc_legal      = (bus.pc <= LIMIT) && (bus.pc[1:0] == 2'b00);
    // A response arriving together with flush is dropped, as is any in DRAIN.
    assign ack_push      = (state_reg == WAIT) && bus.imem_ack && !bus.flush;
    assign fault_push    = accept && !pc_legal;
    // The two push sources are exclusive: accept only happens in IDLE.
    assign push          = ack_push || fault_push;
    assign push_instr    = fault_push ? NOP : bus.imem_rdata;
    assign push_pc       = fault_push ? bus.pc : addr_reg;
    assign queue_valid   = (count_reg != '0);
    assign pop           = queue_valid && bus.instr_ready && !bus.flush;

    // Per-entry write enables for the queue storage
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Request FSM: one outstanding memory read, registered req/addr/fault
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
            addr_reg  <= '0;
            fault_reg <= 1'b0;
        end else begin
            fault_reg <= fault_push;
            case (state_reg)
                IDLE: begin
                    if (accept && pc_legal) begin
                        state_reg <= WAIT;
                        req_reg   <= 1'b1;
                        addr_reg  <= bus.pc;
                    end
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        state_reg <= IDLE;
                        req_reg   <= 1'b0;
                    end else if (bus.flush) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.imem_ack) begin
                        state_reg <= IDLE;
                        req_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    // Queue storage; entries are cleared on reset so the head reads zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (wr_en[i]) begin
                    instr_mem[i] <= push_instr;
                    pc_mem[i]    <= push_pc;
                end
            end
        end
    end

    // Queue pointers and occupancy; flush empties the queue outright
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (bus.flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign bus.pc_ready    = pc_ready_next;
    assign bus.imem_req    = req_reg;
    assign bus.imem_addr   = addr_reg;
    assign bus.addr_fault  = fault_reg;
    assign bus.instr_valid = queue_valid;
    assign bus.instr       = instr_mem[rd_ptr_reg];
    assign bus.instr_pc    = pc_mem[rd_ptr_reg];
endmodule
